// File: rtl/fabric_config_loader_if.sv
// Bitstream handshake plus configuration write bus for fabric_config_loader.
// The host drives the bitstream (master); the loader accepts bits and drives cfg writes (slave).
interface fabric_config_loader_if #(
    parameter int ADDR_W     = 8,
    parameter int FRAME_BITS = 33
);
    logic                  bs_valid;
    logic                  bs_data;
    logic                  bs_ready;
    logic [ADDR_W-1:0]     cfg_addr;
    logic [FRAME_BITS-1:0] cfg_data;
    logic                  cfg_we;

    modport master (
        output bs_valid, bs_data,
        input  bs_ready, cfg_addr, cfg_data, cfg_we
    );

    modport slave (
        input  bs_valid, bs_data,
        output bs_ready, cfg_addr, cfg_data, cfg_we
    );
endinterface

// File: rtl/fabric_config_loader.sv
// Bit-serial fabric configuration loader: header count, LSB-first frames, one write per frame.
// Define CFG_PARITY_EN to add a per-frame even-parity bit (PARITY state) ahead of each write.
module fabric_config_loader #(
    parameter int NUM_FRAMES = 43,
    parameter int FRAME_BITS = 33,
    parameter int ADDR_W     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    fabric_config_loader_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   fabric_en
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;
`ifdef CFG_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd6;
`endif

    logic [2:0]            state_q,     state_d;
    logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [ADDR_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [ADDR_W-1:0]     count_q,     count_d;
    logic [FRAME_BITS-1:0] data_q,      data_d;
    logic [ADDR_W-1:0]     cfg_addr_q,  cfg_addr_d;
    logic [FRAME_BITS-1:0] cfg_data_q,  cfg_data_d;

    logic ready_state;
    logic busy_state;
    logic accept;

`ifdef CFG_PARITY_EN
    assign ready_state = (state_q == S_HEADER) || (state_q == S_LOAD) || (state_q == S_PARITY);
`else
    assign ready_state = (state_q == S_HEADER) || (state_q == S_LOAD);
`endif
    assign busy_state = ready_state || (state_q == S_WRITE);
    assign accept     = bus.bs_valid && ready_state;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        count_d     = count_q;
        data_d      = data_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d     = S_HEADER;
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    count_d     = '0;
                    data_d      = '0;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    count_d = {bus.bs_data, count_q[ADDR_W-1:1]};
                    if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        bit_cnt_d = '0;
                        if (count_d == '0)
                            state_d = S_DONE;
                        else if (count_d > ADDR_W'(NUM_FRAMES))
                            state_d = S_ERROR;
                        else
                            state_d = S_LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    data_d = {bus.bs_data, data_q[FRAME_BITS-1:1]};
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        bit_cnt_d = '0;
`ifdef CFG_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d    = S_WRITE;
                        cfg_addr_d = frame_cnt_q;
                        cfg_data_d = data_d;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef CFG_PARITY_EN
            S_PARITY: begin
                // Even parity over data plus parity bit: the bit must equal the data XOR.
                if (accept) begin
                    if ((^data_q) == bus.bs_data) begin
                        state_d    = S_WRITE;
                        cfg_addr_d = frame_cnt_q;
                        cfg_data_d = data_q;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
`endif
            S_WRITE: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = (frame_cnt_d == count_q) ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any busy-state transition and leaves the last written frame visible.
        if (abort && busy_state) begin
            state_d     = S_IDLE;
            frame_cnt_d = frame_cnt_q;
            cfg_addr_d  = cfg_addr_q;
            cfg_data_d  = cfg_data_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            count_q     <= '0;
            data_q      <= '0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            count_q     <= count_d;
            data_q      <= data_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
        end
    end

    assign bus.bs_ready = ready_state;
    assign bus.cfg_we   = (state_q == S_WRITE) && !abort;
    assign bus.cfg_addr = cfg_addr_q;
    assign bus.cfg_data = cfg_data_q;
    assign busy         = busy_state;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign fabric_en    = (state_q == S_DONE);
endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Bit-serial configuration controller for the FPGA fabric.
- Receives a bitstream over a valid/ready handshake and unpacks it into frames.
- Writes each frame into one configuration target (logic tile LUT+mux memory or switch box config) via an address/data/write-enable bus.
- Sequences fabric bring-up: fabric outputs are enabled only after a complete, error-free load.

Parameters:
- NUM_FRAMES, 43, number of addressable config targets (38 logic tiles + 5 switch boxes).
- FRAME_BITS, 33, bits per frame (tile: 32 LUT bits + 1 mux-select bit; switch boxes use bits [15:0], upper bits written as loaded).
- ADDR_W, 8, width of cfg_addr and of the header frame-count field.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when state is IDLE, DONE or ERROR.
- abort  input  1  level; while high in any busy state, return to IDLE next cycle.
- bs_valid  input  1  bitstream bit valid.
- bs_data  input  1  bitstream bit.
- bs_ready  output  1  loader accepts a bit this cycle.
- cfg_addr  output  ADDR_W  target frame index.
- cfg_data  output  FRAME_BITS  frame contents.
- cfg_we  output  1  one-cycle write strobe.
- busy  output  1  high in HEADER, LOAD, PARITY, WRITE.
- done  output  1  sticky, high in DONE.
- error  output  1  sticky, high in ERROR.
- fabric_en  output  1  high only in DONE; gates fabric outputs.

Behaviour:
- Reset:
  - state=IDLE; all counters and shift registers cleared.
  - All outputs 0: bs_ready, cfg_we, cfg_addr, cfg_data, busy, done, error, fabric_en.
  - Reset mid-load discards the partial frame; no cfg_we is issued.
- Transfer rule: a bit is accepted when bs_valid && bs_ready on a rising clock edge. Bits are LSB-first.
- bs_ready is a registered-state decode: high exactly in HEADER, LOAD and PARITY.
- States:
  - IDLE: on start -> HEADER. Clear bit counter, frame counter, done, error.
  - HEADER: shift in ADDR_W bits to form count N. After the last bit:
    - N==0 -> DONE.
    - N>NUM_FRAMES -> ERROR.
    - otherwise -> LOAD.
  - LOAD: shift FRAME_BITS bits into the data register. After the last bit -> PARITY if CFG_PARITY_EN is defined, else WRITE.
  - WRITE: lasts exactly one cycle.
    - cfg_we=1, cfg_addr=frame counter, cfg_data=assembled frame.
    - Then increment the frame counter.
    - If the counter reaches N -> DONE, else -> LOAD.
  - DONE: done=1, fabric_en=1. On start -> HEADER (new load, fabric_en drops).
  - ERROR: error=1, fabric_en=0. On start -> HEADER.
- Latency:
  - Last frame bit accepted at edge t -> cfg_we high in cycle t+1, without parity.
  - Last WRITE cycle -> DONE the following cycle.
- cfg_data and cfg_addr hold their last written values outside WRITE.
- Boundary conditions:
  - bs_valid low stalls the counters, with no timeout.
  - start while busy is ignored.
  - abort has priority over every transition except reset. It suppresses any pending cfg_we and clears done and fabric_en.
  - Frame indices are 0..N-1 with no wrap; the header range check guarantees no out-of-range address.
  - The bit counter width is ceil(log2(FRAME_BITS+1)).

Optional Feature:
- Macro: CFG_PARITY_EN.
- Defined:
  - After each frame the loader accepts one extra bit in state PARITY.
  - Parity is even over the FRAME_BITS data bits plus the parity bit.
  - Match -> WRITE.
  - Mismatch -> ERROR; no cfg_we for that frame. Frames already written stay written, and fabric_en stays 0.
- Undefined: the PARITY state is absent and LOAD goes directly to WRITE.

Test Plan:
- Reset then idle: no start for 20 cycles -> all outputs 0, bs_ready=0.
- Header N=2, frames 0x1_0000_00FF and 0x0_8000_0001, bs_valid always high:
  - cfg_we pulses at addr 0 with 0x1_0000_00FF, then at addr 1 with 0x0_8000_0001.
  - done=1 and fabric_en=1 one cycle after the second pulse.
  - Total cycles from start to done = 8+2*33+2+2, plus 2 extra cycles with CFG_PARITY_EN.
- Header N=44 -> ERROR after the 8th header bit; error=1, no cfg_we, and bs_ready=0 from then on.
- Header N=0 -> DONE directly; no cfg_we; fabric_en=1.
- Random bs_valid gaps (50% duty) with N=3: the written frames are identical to the gapless run, and cfg_we fires exactly 3 times.
- Abort asserted after 10 bits of frame 1: IDLE next cycle, no cfg_we for frame 1, busy=0. A subsequent start reloads cleanly.
- With CFG_PARITY_EN, a corrupted parity bit on frame 0 -> ERROR, zero cfg_we pulses. A correct parity bit -> normal write.
